// File: rtl/contador_param.sv
// contador_param -- parametrised timebase / event counter.
//
// Counts 0..MAX_VAL up or down, one step every PRESCALE enabled cycles.
// It can wrap modulo MAX_VAL+1 or saturate at the limits.
//
// Ports:
//   clk       rising-edge system clock
//   rst       synchronous active-high reset (overrides everything)
//   enable    gates both the prescaler and the counter
//   up_dn     1 = count up, 0 = count down
//   sat       1 = saturate at the limits, 0 = wrap
//   clr       synchronous clear of count, prescaler and sticky overflow
//   load      synchronous parallel load of load_val (clamped to MAX_VAL)
//   load_val  value to load
//   cmp_val   compare value for match
//   out       registered count
//   cout      one-cycle pulse after an up-wrap MAX_VAL->0
//   bout      one-cycle pulse after a down-wrap 0->MAX_VAL
//   tc        terminal count for the current direction (combinational)
//   match     out == cmp_val (combinational)
//   ovf       sticky flag: any wrap or blocked saturating step
//
// Edge priority: rst > clr > load > count step.
module contador_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             bout,
  output logic             tc,
  output logic             match,
  output logic             ovf
);

  // Prescaler index width; a single bit is kept when PRESCALE is 1 so
  // the vector is never zero-width.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1'b1);
  localparam logic [PW-1:0]    ZERO_P  = {PW{1'b0}};
  localparam logic [PW-1:0]    ONE_P   = PW'(1'b1);
  localparam logic [PW-1:0]    P_LAST  = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [PW-1:0]    p_q,    p_d;
  logic             cout_q, cout_d;
  logic             bout_q, bout_d;
  logic             ovf_q,  ovf_d;

  // Limit tests are done one bit wider so that a MAX_VAL of 2**WIDTH-1
  // and a load_val above MAX_VAL compare without any truncation.
  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   load_ext_s;

  assign cnt_ext_s  = {1'b0, cnt_q};
  assign load_ext_s = {1'b0, load_val};

  // Next-state logic: clear, load, prescaler and the count step.
  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    ovf_d  = ovf_q;
    cout_d = 1'b0;
    bout_d = 1'b0;

    if (clr) begin
      cnt_d = ZERO_W;
      p_d   = ZERO_P;
      ovf_d = 1'b0;
    end else if (load) begin
      p_d = ZERO_P;
      if (load_ext_s > MAX_EXT) begin
        cnt_d = MAX_W;
      end else begin
        cnt_d = load_val;
      end
    end else if (enable) begin
      if (p_q == P_LAST) begin
        // Step fires on the last enabled cycle of the prescale period.
        p_d = ZERO_P;
        if (up_dn) begin
          if (cnt_ext_s < MAX_EXT) begin
            cnt_d = cnt_q + ONE_W;
          end else if (sat) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d  = ZERO_W;
            cout_d = 1'b1;
            ovf_d  = 1'b1;
          end
        end else begin
          if (cnt_q != ZERO_W) begin
            cnt_d = cnt_q - ONE_W;
          end else if (sat) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d  = MAX_W;
            bout_d = 1'b1;
            ovf_d  = 1'b1;
          end
        end
      end else begin
        p_d = p_q + ONE_P;
      end
    end else begin
      // Disabled: prescaler and count hold; pulses drop.
      p_d = p_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= ZERO_W;
      p_q    <= ZERO_P;
      cout_q <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      cout_q <= cout_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out   = cnt_q;
  assign cout  = cout_q;
  assign bout  = bout_q;
  assign ovf   = ovf_q;
  assign tc    = up_dn ? (cnt_q == MAX_W) : (cnt_q == ZERO_W);
  assign match = (cnt_q == cmp_val);

endmodule

// File: tb/tb_contador_param.sv
// Testbench for contador_param: three instances share one set of inputs:
//   a: defaults (MAX_VAL=255, PRESCALE=1)
//   b: MAX_VAL=9
//   c: PRESCALE=4
// Every cycle, a reference model pushes the expected outputs to a queue
// and the queue is popped and compared #1 after the clock edge.
// Directed constant checks cover the headline scenarios.
module tb_contador_param;

  logic       clk = 1'b0;
  logic       rst, enable, up_dn, sat, clr, load;
  logic [7:0] load_val, cmp_val;

  logic [7:0] out_a, out_b, out_c;
  logic       cout_a, bout_a, tc_a, match_a, ovf_a;
  logic       cout_b, bout_b, tc_b, match_b, ovf_b;
  logic       cout_c, bout_c, tc_c, match_c, ovf_c;

  always #5 clk = ~clk;

  contador_param u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .sat(sat),
    .clr(clr), .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .out(out_a), .cout(cout_a), .bout(bout_a), .tc(tc_a),
    .match(match_a), .ovf(ovf_a));

  contador_param #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .sat(sat),
    .clr(clr), .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .out(out_b), .cout(cout_b), .bout(bout_b), .tc(tc_b),
    .match(match_b), .ovf(ovf_b));

  contador_param #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(4)) u_dut_c (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .sat(sat),
    .clr(clr), .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .out(out_c), .cout(cout_c), .bout(bout_c), .tc(tc_c),
    .match(match_c), .ovf(ovf_c));

  // Packed observation per instance: {out, cout, bout, ovf, tc, match}.
  logic [12:0] obs_a, obs_b, obs_c;
  assign obs_a = {out_a, cout_a, bout_a, ovf_a, tc_a, match_a};
  assign obs_b = {out_b, cout_b, bout_b, ovf_b, tc_b, match_b};
  assign obs_c = {out_c, cout_c, bout_c, ovf_c, tc_c, match_c};

  int n_vec = 0;
  int n_err = 0;

  int MAXV [3] = '{255, 9, 255};
  int PRE  [3] = '{1, 1, 4};
  int m_out [3];
  int m_p   [3];
  bit m_ovf [3];
  bit m_cout[3];
  bit m_bout[3];

  logic [38:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model one clock edge for every instance and return the packed expectation.
  task automatic model_step(output logic [38:0] e);
    for (int d = 0; d < 3; d++) begin
      bit tcv, mv;
      m_cout[d] = 1'b0;
      m_bout[d] = 1'b0;
      if (rst || clr) begin
        m_out[d] = 0; m_p[d] = 0; m_ovf[d] = 1'b0;
      end else if (load) begin
        m_out[d] = (int'(load_val) > MAXV[d]) ? MAXV[d] : int'(load_val);
        m_p[d] = 0;
      end else if (enable) begin
        if (m_p[d] == PRE[d] - 1) begin
          m_p[d] = 0;
          if (up_dn) begin
            if (m_out[d] == MAXV[d]) begin
              m_ovf[d] = 1'b1;
              if (!sat) begin m_out[d] = 0; m_cout[d] = 1'b1; end
            end else begin
              m_out[d] = m_out[d] + 1;
            end
          end else begin
            if (m_out[d] == 0) begin
              m_ovf[d] = 1'b1;
              if (!sat) begin m_out[d] = MAXV[d]; m_bout[d] = 1'b1; end
            end else begin
              m_out[d] = m_out[d] - 1;
            end
          end
        end else begin
          m_p[d] = m_p[d] + 1;
        end
      end
      tcv = up_dn ? (m_out[d] == MAXV[d]) : (m_out[d] == 0);
      mv  = (m_out[d] == int'(cmp_val));
      e[d*13 +: 13] = {8'(m_out[d]), m_cout[d], m_bout[d], m_ovf[d], tcv, mv};
    end
  endtask

  // Drive one cycle of inputs, push the expectation, then pop and compare.
  task automatic cyc(input logic r, input logic c, input logic l,
                     input logic en, input logic u, input logic s,
                     input logic [7:0] lv);
    logic [38:0] e;
    rst = r; clr = c; load = l; enable = en; up_dn = u; sat = s;
    load_val = lv;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_a", 32'(obs_a), 32'(e[12:0]));
    check_eq("sb_b", 32'(obs_b), 32'(e[25:13]));
    check_eq("sb_c", 32'(obs_c), 32'(e[38:26]));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; enable = 1'b0;
    up_dn = 1'b1; sat = 1'b0; load_val = 8'd0; cmp_val = 8'd5;
    for (int d = 0; d < 3; d++) begin
      m_out[d] = 0; m_p[d] = 0; m_ovf[d] = 1'b0;
    end
    @(negedge clk);

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    check_eq("rst_out", 32'(out_a), 32'd0);
    check_eq("rst_ovf", 32'(ovf_a), 32'd0);

    // Full up count on the default instance
    for (int i = 0; i < 255; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("up_255", 32'(out_a), 32'd255);
    check_eq("up_tc", 32'(tc_a), 32'd1);
    check_eq("up_ovf_pre", 32'(ovf_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("wrap_out", 32'(out_a), 32'd0);
    check_eq("wrap_cout", 32'(cout_a), 32'd1);
    check_eq("wrap_ovf", 32'(ovf_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("cout_drop", 32'(cout_a), 32'd0);
    check_eq("ovf_sticky", 32'(ovf_a), 32'd1);

    // Down wrap at MAX_VAL=9, then saturating down at 0
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check_eq("dn_wrap9", 32'(out_b), 32'd9);
    check_eq("dn_bout", 32'(bout_b), 32'd1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    check_eq("dn_to0", 32'(out_b), 32'd0);
    check_eq("dn_tc0", 32'(tc_b), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    check_eq("dn_sat_out", 32'(out_b), 32'd0);
    check_eq("dn_sat_bout", 32'(bout_b), 32'd0);
    check_eq("dn_sat_ovf", 32'(ovf_b), 32'd1);

    // Prescaler: step every 4th enabled cycle, enable gap, load mid-period
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("pre_hold", 32'(out_c), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("pre_step", 32'(out_c), 32'd1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("pre_gap_hold", 32'(out_c), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("pre_gap_step", 32'(out_c), 32'd2);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd37);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("pre_load_hold", 32'(out_c), 32'd37);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("pre_load_step", 32'(out_c), 32'd38);

    // Same edge priority: clr beats load; load clamps to MAX_VAL
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd37);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd99);
    check_eq("clr_load_out", 32'(out_a), 32'd0);
    check_eq("clr_load_ovf", 32'(ovf_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd200);
    check_eq("load_clamp", 32'(out_b), 32'd9);
    check_eq("load_200", 32'(out_a), 32'd200);

    // Compare match, then reset mid-count
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("match_5", 32'(match_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("match_6", 32'(match_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("pre_rst_7", 32'(out_a), 32'd7);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("rst_mid_out", 32'(out_a), 32'd0);
    check_eq("rst_mid_pulse", 32'({cout_a, bout_a, ovf_a}), 32'd0);

    // Saturate up at 255, then release to wrap
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
    check_eq("sat_hold", 32'(out_a), 32'd255);
    check_eq("sat_ovf", 32'(ovf_a), 32'd1);
    check_eq("sat_cout", 32'(cout_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    check_eq("unsat_out", 32'(out_a), 32'd0);
    check_eq("unsat_cout", 32'(cout_a), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cmp_val = 8'($urandom_range(0, 12));
      cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
